// File: rtl/lcd_window_stats.sv
// lcd_window_stats
// Collects the 3x3 window that the LCD controller streams out one pixel per
// cycle. For each window it computes the sum, the maximum and its scan index,
// the minimum and the centre pixel. Each result is offered on a valid/ready
// port.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   pix_in       pixel from the controller's dataout
//   pix_valid    controller's output_valid; high for NPIX consecutive cycles
//   res_ready    downstream accepts the held result
//   res_valid    result registers hold an unconsumed window result
//   res_sum      sum of the window pixels
//   res_max      maximum pixel
//   res_max_idx  scan index of the first occurrence of the maximum
//   res_min      minimum pixel
//   res_center   pixel at the centre scan index
//   overrun      sticky; a new result replaced one that was never consumed
//   frag_err     one-cycle pulse; a window ended before all pixels arrived
module lcd_window_stats #(
    parameter int unsigned DW   = 8,
    parameter int unsigned NPIX = 9,
    parameter int unsigned SW   = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_valid,
    input  logic          res_ready,
    output logic          res_valid,
    output logic [SW-1:0] res_sum,
    output logic [DW-1:0] res_max,
    output logic [3:0]    res_max_idx,
    output logic [DW-1:0] res_min,
    output logic [DW-1:0] res_center,
    output logic          overrun,
    output logic          frag_err
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST_IDX   = CW'(NPIX - 1);
    localparam logic [CW-1:0] CENTER_IDX = CW'(NPIX / 2);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] acc_sum, acc_sum_n;
    logic [DW-1:0] acc_max, acc_max_n;
    logic [DW-1:0] acc_min, acc_min_n;
    logic [3:0]    acc_idx, acc_idx_n;
    logic [DW-1:0] acc_center, acc_center_n;

    logic          res_valid_n;
    logic [SW-1:0] res_sum_n;
    logic [DW-1:0] res_max_n;
    logic [3:0]    res_max_idx_n;
    logic [DW-1:0] res_min_n;
    logic [DW-1:0] res_center_n;
    logic          overrun_n;
    logic          frag_err_n;

    // Current pixel folded into the running statistics.
    // The strict compare keeps the lowest index when the maximum is tied.
    logic [SW-1:0] sum_fold_c;
    logic          new_max_c;
    logic          new_min_c;

    assign sum_fold_c = acc_sum + SW'(pix_in);
    assign new_max_c  = pix_in > acc_max;
    assign new_min_c  = pix_in < acc_min;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, accumulator and result logic
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        acc_sum_n     = acc_sum;
        acc_max_n     = acc_max;
        acc_min_n     = acc_min;
        acc_idx_n     = acc_idx;
        acc_center_n  = acc_center;
        res_valid_n   = res_valid && !res_ready;
        res_sum_n     = res_sum;
        res_max_n     = res_max;
        res_max_idx_n = res_max_idx;
        res_min_n     = res_min;
        res_center_n  = res_center;
        overrun_n     = overrun;
        frag_err_n    = 1'b0;

        case (state)
            IDLE: begin
                if (pix_valid) begin
                    acc_sum_n    = SW'(pix_in);
                    acc_max_n    = pix_in;
                    acc_min_n    = pix_in;
                    acc_idx_n    = 4'd0;
                    acc_center_n = '0;
                    cnt_n        = CW'(1);
                    state_n      = COLLECT;
                end
            end
            COLLECT: begin
                if (pix_valid) begin
                    acc_sum_n = sum_fold_c;
                    if (new_max_c) begin
                        acc_max_n = pix_in;
                        acc_idx_n = 4'(cnt);
                    end
                    if (new_min_c) begin
                        acc_min_n = pix_in;
                    end
                    if (cnt == CENTER_IDX) begin
                        acc_center_n = pix_in;
                    end
                    if (cnt == LAST_IDX) begin
                        // The last pixel goes straight into the result registers.
                        state_n       = IDLE;
                        cnt_n         = '0;
                        res_sum_n     = sum_fold_c;
                        res_max_n     = new_max_c ? pix_in : acc_max;
                        res_max_idx_n = new_max_c ? 4'(cnt) : acc_idx;
                        res_min_n     = new_min_c ? pix_in : acc_min;
                        res_center_n  = acc_center;
                        res_valid_n   = 1'b1;
                        if (res_valid && !res_ready) begin
                            overrun_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end else begin
                    // The window is fragmented: drop the partial statistics.
                    frag_err_n   = 1'b1;
                    state_n      = IDLE;
                    cnt_n        = '0;
                    acc_sum_n    = '0;
                    acc_max_n    = '0;
                    acc_min_n    = '0;
                    acc_idx_n    = 4'd0;
                    acc_center_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            acc_sum     <= '0;
            acc_max     <= '0;
            acc_min     <= '0;
            acc_idx     <= 4'd0;
            acc_center  <= '0;
            res_valid   <= 1'b0;
            res_sum     <= '0;
            res_max     <= '0;
            res_max_idx <= 4'd0;
            res_min     <= '0;
            res_center  <= '0;
            overrun     <= 1'b0;
            frag_err    <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            acc_sum     <= acc_sum_n;
            acc_max     <= acc_max_n;
            acc_min     <= acc_min_n;
            acc_idx     <= acc_idx_n;
            acc_center  <= acc_center_n;
            res_valid   <= res_valid_n;
            res_sum     <= res_sum_n;
            res_max     <= res_max_n;
            res_max_idx <= res_max_idx_n;
            res_min     <= res_min_n;
            res_center  <= res_center_n;
            overrun     <= overrun_n;
            frag_err    <= frag_err_n;
        end
    end

endmodule

// File: tb/tb_lcd_window_stats.sv
// Directed, table-driven bench for lcd_window_stats.
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge.
module tb_lcd_window_stats;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        res_ready;
    logic        res_valid;
    logic [11:0] res_sum;
    logic [7:0]  res_max;
    logic [3:0]  res_max_idx;
    logic [7:0]  res_min;
    logic [7:0]  res_center;
    logic        overrun;
    logic        frag_err;

    int checks   = 0;
    int failures = 0;

    lcd_window_stats dut (
        .clk         (clk),
        .reset       (reset),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .res_ready   (res_ready),
        .res_valid   (res_valid),
        .res_sum     (res_sum),
        .res_max     (res_max),
        .res_max_idx (res_max_idx),
        .res_min     (res_min),
        .res_center  (res_center),
        .overrun     (overrun),
        .frag_err    (frag_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pix [9];
        logic [11:0] sum;
        logic [7:0]  mx;
        logic [3:0]  idx;
        logic [7:0]  mn;
        logic [7:0]  ctr;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives one window; the last pixel is sampled by the next rising edge.
    task automatic feed(input logic [7:0] p [9]);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_in    = p[i];
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        pix_valid = 1'b0;
        pix_in    = 8'd0;
    endtask

    task automatic chk_result(input string tag, input vec_t v);
        chk({tag, ".valid"},  32'(res_valid),   32'd1);
        chk({tag, ".sum"},    32'(res_sum),     32'(v.sum));
        chk({tag, ".max"},    32'(res_max),     32'(v.mx));
        chk({tag, ".idx"},    32'(res_max_idx), 32'(v.idx));
        chk({tag, ".min"},    32'(res_min),     32'(v.mn));
        chk({tag, ".center"}, 32'(res_center),  32'(v.ctr));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"},  32'(res_valid),   32'd0);
        chk({tag, ".sum"},    32'(res_sum),     32'd0);
        chk({tag, ".max"},    32'(res_max),     32'd0);
        chk({tag, ".idx"},    32'(res_max_idx), 32'd0);
        chk({tag, ".min"},    32'(res_min),     32'd0);
        chk({tag, ".center"}, 32'(res_center),  32'd0);
        chk({tag, ".overrun"}, 32'(overrun),    32'd0);
        chk({tag, ".frag"},   32'(frag_err),    32'd0);
    endtask

    initial begin
        logic [7:0] seq [9];
        vec_t       v;

        vecs[0].pix = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        vecs[0].sum = 12'd45;   vecs[0].mx = 8'd9;   vecs[0].idx = 4'd8; vecs[0].mn = 8'd1;   vecs[0].ctr = 8'd5;
        vecs[1].pix = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[1].sum = 12'd2295; vecs[1].mx = 8'd255; vecs[1].idx = 4'd0; vecs[1].mn = 8'd255; vecs[1].ctr = 8'd255;
        vecs[2].pix = '{8'd7, 8'd3, 8'd9, 8'd9, 8'd0, 8'd2, 8'd9, 8'd1, 8'd4};
        vecs[2].sum = 12'd44;   vecs[2].mx = 8'd9;   vecs[2].idx = 4'd2; vecs[2].mn = 8'd0;   vecs[2].ctr = 8'd0;
        vecs[3].pix = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        vecs[3].sum = 12'd45;   vecs[3].mx = 8'd9;   vecs[3].idx = 4'd0; vecs[3].mn = 8'd1;   vecs[3].ctr = 8'd5;
        vecs[4].pix = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd200};
        vecs[4].sum = 12'd200;  vecs[4].mx = 8'd200; vecs[4].idx = 4'd8; vecs[4].mn = 8'd0;   vecs[4].ctr = 8'd0;

        reset     = 1'b1;
        pix_in    = 8'd0;
        pix_valid = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        idle_cycle();

        // Table-driven windows, each consumed right away.
        for (int t = 0; t < 5; t++) begin
            feed(vecs[t].pix);
            idle_cycle();
            chk_result($sformatf("vec%0d", t), vecs[t]);
            idle_cycle();
            chk($sformatf("vec%0d.drop", t), 32'(res_valid), 32'd0);
            chk($sformatf("vec%0d.ovr", t), 32'(overrun), 32'd0);
        end

        // Fragmented window: 4 pixels, then a drop.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_in    = 8'(i + 1);
        end
        idle_cycle();
        chk("frag.before", 32'(frag_err), 32'd0);
        idle_cycle();
        chk("frag.pulse", 32'(frag_err), 32'd1);
        chk("frag.valid", 32'(res_valid), 32'd0);
        idle_cycle();
        chk("frag.clear", 32'(frag_err), 32'd0);
        feed(vecs[0].pix);
        idle_cycle();
        chk_result("after_frag", vecs[0]);
        idle_cycle();

        // Back-to-back windows with res_ready high: no overrun.
        feed(vecs[0].pix);
        @(negedge clk);
        pix_valid = 1'b1;
        pix_in    = vecs[3].pix[0];
        chk_result("b2b.first", vecs[0]);
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            pix_in = vecs[3].pix[i];
        end
        idle_cycle();
        chk_result("b2b.second", vecs[3]);
        chk("b2b.ovr", 32'(overrun), 32'd0);
        idle_cycle();

        // Overrun: 1..18 contiguous, res_ready low.
        res_ready = 1'b0;
        for (int i = 0; i < 9; i++) seq[i] = 8'(i + 1);
        feed(seq);
        for (int i = 0; i < 9; i++) seq[i] = 8'(i + 10);
        @(negedge clk);
        pix_valid = 1'b1;
        pix_in    = seq[0];
        chk_result("ovr.first", vecs[0]);
        chk("ovr.first_flag", 32'(overrun), 32'd0);
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            pix_in = seq[i];
        end
        idle_cycle();
        v.sum = 12'd126; v.mx = 8'd18; v.idx = 4'd8; v.mn = 8'd10; v.ctr = 8'd14;
        chk_result("ovr.second", v);
        chk("ovr.flag", 32'(overrun), 32'd1);
        idle_cycle();
        chk("ovr.hold_valid", 32'(res_valid), 32'd1);
        chk("ovr.hold_sum", 32'(res_sum), 32'd126);
        res_ready = 1'b1;
        idle_cycle();
        chk("ovr.drained", 32'(res_valid), 32'd0);
        chk("ovr.sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a window.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_in    = 8'(i + 1);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        idle_cycle();
        chk("midrst.nofrag", 32'(frag_err), 32'd0);
        feed(vecs[0].pix);
        idle_cycle();
        chk_result("after_rst", vecs[0]);
        chk("after_rst.ovr", 32'(overrun), 32'd0);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
